// File: rtl/toggle_energy_monitor.sv
// rtl/toggle_energy_monitor.sv - counts net transitions over a window and reports switching energy
// IDLE -> MEASURE (N comparisons) -> DONE (one-cycle pulse) -> IDLE.
module toggle_energy_monitor #(
  parameter int WIDTH   = 4,
  parameter int VOLTAGE = 5,
  parameter int CAP_PF  = 50
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] mon_in,
  input  logic             start,
  input  logic [7:0]       window,
  output logic             busy,
  output logic             done,
  output logic [11:0]      toggles,
  output logic [23:0]      energy_pj,
  output logic [1:0]       hot_bit
);

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

  localparam logic [23:0] ENERGY_K = 24'(VOLTAGE * VOLTAGE * CAP_PF);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       bit_cnt_q [WIDTH];
  logic [7:0]       bit_cnt_d [WIDTH];
  logic [11:0]      total_q, total_d;
  logic [11:0]      toggles_q, toggles_d;
  logic [23:0]      energy_q, energy_d;
  logic [1:0]       hot_q, hot_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] diff;
  logic [7:0]       bit_inc [WIDTH];
  logic [15:0]      total_sum;
  logic [11:0]      total_inc;
  logic [7:0]       max_c;
  logic [1:0]       hot_c;

  // Counts as they will stand after this edge's comparison, so the DONE edge includes it.
  always_comb begin
    diff      = mon_in ^ prev_q;
    total_sum = {4'd0, total_q};
    max_c     = 8'd0;
    hot_c     = 2'd0;
    for (int i = 0; i < WIDTH; i++) begin
      bit_inc[i] = (diff[i] && bit_cnt_q[i] != 8'hFF) ? bit_cnt_q[i] + 8'd1 : bit_cnt_q[i];
      total_sum  = total_sum + 16'(diff[i]);
    end
    total_inc = (total_sum > 16'd4095) ? 12'hFFF : total_sum[11:0];
    // Strict compare keeps the lowest index on ties.
    for (int i = 0; i < WIDTH; i++) begin
      if (bit_inc[i] > max_c) begin
        max_c = bit_inc[i];
        hot_c = i[1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    total_d   = total_q;
    toggles_d = toggles_q;
    energy_d  = energy_q;
    hot_d     = hot_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          prev_d    = mon_in;
          cnt_d     = window;
          bit_cnt_d = '{default: '0};
          total_d   = 12'd0;
          if (window == 8'd0) begin
            state_d   = DONE;
            toggles_d = 12'd0;
            energy_d  = 24'd0;
            hot_d     = 2'd0;
          end else begin
            state_d = MEASURE;
          end
        end
      end
      MEASURE: begin
        prev_d    = mon_in;
        cnt_d     = cnt_q - 8'd1;
        bit_cnt_d = bit_inc;
        total_d   = total_inc;
        if (cnt_q == 8'd1) begin
          state_d   = DONE;
          toggles_d = total_inc;
          energy_d  = ENERGY_K * {12'd0, total_inc};
          hot_d     = hot_c;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MEASURE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      cnt_q     <= 8'd0;
      bit_cnt_q <= '{default: '0};
      total_q   <= 12'd0;
      toggles_q <= 12'd0;
      energy_q  <= 24'd0;
      hot_q     <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      total_q   <= total_d;
      toggles_q <= toggles_d;
      energy_q  <= energy_d;
      hot_q     <= hot_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign toggles   = toggles_q;
  assign energy_pj = energy_q;
  assign hot_bit   = hot_q;

endmodule

// File: tb/tb_toggle_energy_monitor.sv
// tb/tb_toggle_energy_monitor.sv - directed self-checking bench for toggle_energy_monitor
module tb_toggle_energy_monitor;

  logic        clk = 1'b0;
  logic        reset_L;
  logic [3:0]  mon_in;
  logic        start;
  logic [7:0]  window;
  logic        busy;
  logic        done;
  logic [11:0] toggles;
  logic [23:0] energy_pj;
  logic [1:0]  hot_bit;

  int checks = 0;
  int errors = 0;

  toggle_energy_monitor dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .mon_in    (mon_in),
    .start     (start),
    .window    (window),
    .busy      (busy),
    .done      (done),
    .toggles   (toggles),
    .energy_pj (energy_pj),
    .hot_bit   (hot_bit)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_toggle;
    mon_in = ~mon_in;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_results(input string tag, input logic [31:0] t, input logic [31:0] e,
                             input logic [31:0] h);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_toggles"}, 32'(toggles), t);
    chk({tag, "_energy"}, 32'(energy_pj), e);
    chk({tag, "_hot"}, 32'(hot_bit), h);
  endtask

  initial begin
    int  n;
    bit  saw_done;

    reset_L = 1'b0;
    start   = 1'b0;
    window  = 8'd0;
    mon_in  = 4'h0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_toggles", 32'(toggles), 32'd0);
    chk("rst_energy", 32'(energy_pj), 32'd0);
    chk("rst_hot", 32'(hot_bit), 32'd0);

    // Start on the very first edge after reset release, window of 4, all bits flipping.
    reset_L = 1'b1;
    start   = 1'b1;
    window  = 8'd4;
    mon_in  = 4'h0;
    tick();
    chk("w4_start_busy", 32'(busy), 32'd1);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      mon_in = (k % 2 == 1) ? 4'hF : 4'h0;
      tick();
      if (k < 4) chk("w4_mid_done", 32'(done), 32'd0);
    end
    chk_results("w4", 32'd16, 32'd20000, 32'd0);
    chk("w4_busy_at_done", 32'(busy), 32'd0);
    tick();
    chk("w4_done_pulse", 32'(done), 32'd0);

    for (int k = 0; k < 20; k++) begin
      mon_in = 4'($urandom);
      tick();
    end
    chk("hold_toggles", 32'(toggles), 32'd16);
    chk("hold_energy", 32'(energy_pj), 32'd20000);
    chk("hold_done", 32'(done), 32'd0);

    // Only net 2 toggles.
    mon_in = 4'h0;
    start  = 1'b1;
    window = 8'd8;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mon_in = mon_in ^ 4'h4;
      tick();
    end
    chk_results("w8", 32'd8, 32'd10000, 32'd2);

    // Zero-length window, starting in the idle cycle right after DONE.
    tick();
    start  = 1'b1;
    window = 8'd0;
    tick();
    start = 1'b0;
    chk_results("w0", 32'd0, 32'd0, 32'd0);
    chk("w0_busy", 32'(busy), 32'd0);
    tick();
    chk("w0_done_clear", 32'(done), 32'd0);
    chk("w0_busy_after", 32'(busy), 32'd0);

    // Three back-to-back 255-cycle windows, start held high throughout.
    start  = 1'b1;
    window = 8'd255;
    mon_in = 4'h0;
    for (int w = 0; w < 3; w++) begin
      tick_toggle();
      chk("w255_start_busy", 32'(busy), 32'd1);
      n = 0;
      do begin
        tick_toggle();
        n++;
      end while (!done && n < 300);
      chk("w255_latency", 32'(n), 32'd255);
      chk_results("w255", 32'd1020, 32'd1275000, 32'd0);
      tick_toggle();
      chk("w255_idle_done", 32'(done), 32'd0);
      chk("w255_idle_busy", 32'(busy), 32'd0);
    end
    start = 1'b0;

    // Asynchronous reset in the middle of a window.
    mon_in = 4'h5;
    start  = 1'b1;
    window = 8'd10;
    tick();
    start  = 1'b0;
    mon_in = 4'hA;
    tick();
    tick();
    #2;
    reset_L = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_toggles", 32'(toggles), 32'd0);
    chk("arst_energy", 32'(energy_pj), 32'd0);
    chk("arst_hot", 32'(hot_bit), 32'd0);
    tick();
    tick();
    reset_L  = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      mon_in = ~mon_in;
      tick();
      if (done) saw_done = 1'b1;
    end
    chk("arst_no_done", 32'(saw_done), 32'd0);
    chk("arst_idle_busy", 32'(busy), 32'd0);

    mon_in = 4'h6;
    start  = 1'b1;
    window = 8'd2;
    tick();
    start = 1'b0;
    chk("w2_busy", 32'(busy), 32'd1);
    tick();
    chk("w2_mid_done", 32'(done), 32'd0);
    tick();
    chk_results("w2_static", 32'd0, 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/toggle_energy_monitor.md
TOGGLE_ENERGY_MONITOR -- requirements
Module: toggle_energy_monitor

Interface
REQ-001 Parameter: WIDTH, 4, number of monitored gate-output nets.
REQ-002 Parameter: VOLTAGE, 5, supply in volts (integer).
REQ-003 Parameter: CAP_PF, 50, load capacitance per net in pF (integer).
REQ-004 Port: clk  in  1  single clock; all state on rising edge.
REQ-005 Port: reset_L  in  1  asynchronous, active-low reset.
REQ-006 Port: mon_in  in  WIDTH  gate outputs under observation, sampled each rising edge.
REQ-007 Port: start  in  1  request a measurement window; sampled only in IDLE.
REQ-008 Port: window  in  8  window length N in cycles, latched with start.
REQ-009 Port: busy  out  1  high while in MEASURE.
REQ-010 Port: done  out  1  one-cycle pulse, results valid.
REQ-011 Port: toggles  out  12  total bit transitions in last window.
REQ-012 Port: energy_pj  out  24  VOLTAGE*VOLTAGE*CAP_PF*toggles, in pJ.
REQ-013 Port: hot_bit  out  2  index of net with most transitions in last window.

Function
REQ-014 FSM states SHALL be IDLE, MEASURE, DONE; encoding free.
REQ-015 IDLE with start=1 at an edge: prev<=mon_in, cnt<=window, accumulators<=0; next MEASURE, or DONE if window=0.
REQ-016 start while MEASURE or DONE SHALL be ignored; no queuing.
REQ-017 MEASURE per edge: each bit i with mon_in[i]!=prev[i] increments per-bit counter i (8 bit) and total counter; prev<=mon_in; cnt decrements.
REQ-018 MEASURE SHALL exit to DONE on the edge where cnt goes 1->0; exactly N comparisons per window.
REQ-019 Total counter SHALL saturate at 4095; per-bit counters saturate at 255.
REQ-020 On the edge entering DONE, toggles, energy_pj, hot_bit SHALL be registered from final counts (that edge's comparison included).
REQ-021 energy_pj SHALL be computed at full precision (max 25*50*4095=5,118,750 fits 24 bits); no truncation for default parameters.
REQ-022 hot_bit SHALL be the lowest index among nets with maximum count; 0 if all counts zero.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-024 toggles, energy_pj, hot_bit SHALL hold their values until the next DONE entry.
REQ-025 busy=1 iff state=MEASURE; done=1 iff state=DONE.
REQ-026 start=1 in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back windows).
REQ-027 Window of N cycles SHALL yield done N+1 edges after the start edge; window=0 yields done 1 edge after, all results 0.

Reset
REQ-028 reset_L=0 SHALL immediately force IDLE, busy=0, done=0, toggles=0, energy_pj=0, hot_bit=0, all counters and prev=0.
REQ-029 Reset assertion mid-MEASURE SHALL discard the window; no done pulse.
REQ-030 After reset_L rises, first start SHALL be honoured on the first edge where reset_L=1.

Verification
REQ-031 window=4, mon_in toggles 0000/1111 each cycle -> done after 5 edges, toggles=16, energy_pj=20000, hot_bit=0.
REQ-032 window=8, only mon_in[2] toggles every cycle -> toggles=8, energy_pj=10000, hot_bit=2.
REQ-033 window=0 -> done on next edge, toggles=0, energy_pj=0, hot_bit=0, busy never high.
REQ-034 window=255, mon_in toggles all bits every cycle for 3 back-to-back windows -> each toggles=1020, energy_pj=1275000; start during busy ignored.
REQ-035 reset_L pulsed low at cycle 3 of window=10 -> outputs 0 asynchronously, no done, new start=1/window=2 with static mon_in -> toggles=0.
REQ-036 Previous results held: after REQ-031 window, 20 idle cycles with mon_in changing -> toggles stays 16.
